// File: rtl/sap1_ctrl_pkg.sv
// Shared control-word bit map, opcode constants and T-state encoding for the SAP-1 CPU.
// Register, IR and ALU blocks index ctrl_n by these names.
package sap1_ctrl_pkg;

    localparam int unsigned NUM_T_DEF  = 5;
    localparam int unsigned CTRL_W_DEF = 16;

    localparam int unsigned CTRL_MI  = 0;
    localparam int unsigned CTRL_RI  = 1;
    localparam int unsigned CTRL_RO  = 2;
    localparam int unsigned CTRL_II  = 3;
    localparam int unsigned CTRL_IO  = 4;
    localparam int unsigned CTRL_AI  = 5;
    localparam int unsigned CTRL_AO  = 6;
    localparam int unsigned CTRL_EO  = 7;
    localparam int unsigned CTRL_SU  = 8;
    localparam int unsigned CTRL_BI  = 9;
    localparam int unsigned CTRL_OI  = 10;
    localparam int unsigned CTRL_CE  = 11;
    localparam int unsigned CTRL_CO  = 12;
    localparam int unsigned CTRL_J   = 13;
    localparam int unsigned CTRL_FI  = 14;
    localparam int unsigned CTRL_HLT = 15;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } tstate_e;

endpackage

// File: rtl/sap1_microcode_rom.sv
// Combinational microcode: {tstate, opcode, flags} -> active-low control word.
// Empty rows come out as all-ones.
module sap1_microcode_rom
    import sap1_ctrl_pkg::*;
(
    input  tstate_e     tstate,
    input  logic [3:0]  opcode,
    input  logic        flag_c,
    input  logic        flag_z,
    output logic [15:0] word_n
);

    logic [15:0] word;

    always_comb begin
        word = '0;
        case (tstate)
            T0: begin
                word[CTRL_CO] = 1'b1;
                word[CTRL_MI] = 1'b1;
            end
            T1: begin
                word[CTRL_RO] = 1'b1;
                word[CTRL_II] = 1'b1;
                word[CTRL_CE] = 1'b1;
            end
            T2: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        word[CTRL_IO] = 1'b1;
                        word[CTRL_MI] = 1'b1;
                    end
                    OP_LDI: begin
                        word[CTRL_IO] = 1'b1;
                        word[CTRL_AI] = 1'b1;
                    end
                    OP_JMP: begin
                        word[CTRL_IO] = 1'b1;
                        word[CTRL_J]  = 1'b1;
                    end
                    OP_JC: begin
                        word[CTRL_IO] = flag_c;
                        word[CTRL_J]  = flag_c;
                    end
                    OP_JZ: begin
                        word[CTRL_IO] = flag_z;
                        word[CTRL_J]  = flag_z;
                    end
                    OP_OUT: begin
                        word[CTRL_AO] = 1'b1;
                        word[CTRL_OI] = 1'b1;
                    end
                    OP_HLT:  word[CTRL_HLT] = 1'b1;
                    OP_NOP:  word = '0;
                    default: word = '0;
                endcase
            end
            T3: begin
                case (opcode)
                    OP_LDA: begin
                        word[CTRL_RO] = 1'b1;
                        word[CTRL_AI] = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        word[CTRL_RO] = 1'b1;
                        word[CTRL_BI] = 1'b1;
                    end
                    OP_STA: begin
                        word[CTRL_AO] = 1'b1;
                        word[CTRL_RI] = 1'b1;
                    end
                    default: word = '0;
                endcase
            end
            T4: begin
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    word[CTRL_EO] = 1'b1;
                    word[CTRL_AI] = 1'b1;
                    word[CTRL_FI] = 1'b1;
                    word[CTRL_SU] = (opcode == OP_SUB);
                end
            end
            default: word = '0;
        endcase
        word_n = ~word;
    end

endmodule

// File: rtl/sap1_control_sequencer.sv
// SAP-1 control sequencer: T-state counter, halt latch and gating around the microcode ROM.
module sap1_control_sequencer
    import sap1_ctrl_pkg::*;
#(
    parameter int unsigned NUM_T  = NUM_T_DEF,
    parameter int unsigned CTRL_W = CTRL_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              step_en,
    input  logic [3:0]        opcode,
    input  logic              flag_c,
    input  logic              flag_z,
    output logic [CTRL_W-1:0] ctrl_n,
    output logic [2:0]        tstate,
    output logic              halted
);

    tstate_e     state_q, state_d;
    logic        halted_q, halted_d;
    logic [15:0] rom_n;
    logic        row_empty;

    sap1_microcode_rom u_rom (
        .tstate (state_q),
        .opcode (opcode),
        .flag_c (flag_c),
        .flag_z (flag_z),
        .word_n (rom_n)
    );

    assign row_empty = (rom_n == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= T0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    // Halt latches on the edge ending T2 and freezes the counter there.
    always_comb begin
        state_d  = state_q;
        halted_d = halted_q;
        if (step_en && !halted_q) begin
            if (state_q == 3'(NUM_T - 1)) begin
                state_d = T0;
            end else if (state_q >= T2 && row_empty) begin
                state_d = T0;
            end else if (state_q == T2 && !rom_n[CTRL_HLT]) begin
                halted_d = 1'b1;
            end else begin
                state_d = tstate_e'(state_q + 3'd1);
            end
        end
    end

    assign ctrl_n = (!rst_n || halted_q) ? '1 : CTRL_W'(rom_n);
    assign tstate = state_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_sap1_control_sequencer.sv
// Directed table-driven bench for the SAP-1 control sequencer, plus hand sequences
// for step freeze, halt, async reset and combinational opcode/flag changes.
module tb_sap1_control_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        step_en;
    logic [3:0]  opcode;
    logic        flag_c;
    logic        flag_z;
    logic [15:0] ctrl_n;
    logic [2:0]  tstate;
    logic        halted;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        step_en;
        logic [3:0]  opcode;
        logic        flag_c;
        logic        flag_z;
        logic [15:0] exp_ctrl;
        logic [2:0]  exp_t;
        logic        exp_halted;
    } vec_t;

    vec_t vecs[$];

    sap1_control_sequencer #(.NUM_T(5), .CTRL_W(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .step_en (step_en),
        .opcode  (opcode),
        .flag_c  (flag_c),
        .flag_z  (flag_z),
        .ctrl_n  (ctrl_n),
        .tstate  (tstate),
        .halted  (halted)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [15:0] c, input logic [2:0] t,
                           input logic h);
        chk({name, ".ctrl_n"}, 32'(ctrl_n), 32'(c));
        chk({name, ".tstate"}, 32'(tstate), 32'(t));
        chk({name, ".halted"}, 32'(halted), 32'(h));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        step_en = 1'b1;
        flag_c  = 1'b0;
        flag_z  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    function automatic void add(input logic [3:0] op, input logic fc, input logic fz,
                                input logic [15:0] c, input logic [2:0] t);
        vecs.push_back('{1'b1, op, fc, fz, c, t, 1'b0});
    endfunction

    // Fetch rows common to every instruction.
    function automatic void add_fetch(input logic [3:0] op, input logic fc, input logic fz);
        add(op, fc, fz, 16'hEFFE, 3'd0);
        add(op, fc, fz, 16'hF7F3, 3'd1);
    endfunction

    initial begin
        rst_n   = 1'b0;
        step_en = 1'b1;
        opcode  = 4'h1;
        flag_c  = 1'b0;
        flag_z  = 1'b0;

        // LDA
        add_fetch(4'h1, 0, 0);
        add(4'h1, 0, 0, 16'hFFEE, 3'd2);
        add(4'h1, 0, 0, 16'hFFDB, 3'd3);
        add(4'h1, 0, 0, 16'hFFFF, 3'd4);
        // SUB
        add_fetch(4'h3, 0, 0);
        add(4'h3, 0, 0, 16'hFFEE, 3'd2);
        add(4'h3, 0, 0, 16'hFDFB, 3'd3);
        add(4'h3, 0, 0, 16'hBE5F, 3'd4);
        // JC not taken: three cycles
        add_fetch(4'h7, 0, 1);
        add(4'h7, 0, 1, 16'hFFFF, 3'd2);
        // JC taken
        add_fetch(4'h7, 1, 0);
        add(4'h7, 1, 0, 16'hDFEF, 3'd2);
        add(4'h7, 1, 0, 16'hFFFF, 3'd3);
        // JZ taken, then not taken with carry set
        add_fetch(4'h8, 0, 1);
        add(4'h8, 0, 1, 16'hDFEF, 3'd2);
        add(4'h8, 0, 1, 16'hFFFF, 3'd3);
        add_fetch(4'h8, 1, 0);
        add(4'h8, 1, 0, 16'hFFFF, 3'd2);
        // OUT
        add_fetch(4'hE, 0, 0);
        add(4'hE, 0, 0, 16'hFBBF, 3'd2);
        add(4'hE, 0, 0, 16'hFFFF, 3'd3);
        // LDI
        add_fetch(4'h5, 0, 0);
        add(4'h5, 0, 0, 16'hFFCF, 3'd2);
        add(4'h5, 0, 0, 16'hFFFF, 3'd3);
        // STA
        add_fetch(4'h4, 0, 0);
        add(4'h4, 0, 0, 16'hFFEE, 3'd2);
        add(4'h4, 0, 0, 16'hFFBD, 3'd3);
        add(4'h4, 0, 0, 16'hFFFF, 3'd4);
        // Undefined opcode behaves as NOP
        add_fetch(4'hA, 0, 0);
        add(4'hA, 0, 0, 16'hFFFF, 3'd2);
        // JMP
        add_fetch(4'h6, 0, 0);
        add(4'h6, 0, 0, 16'hDFEF, 3'd2);
        add(4'h6, 0, 0, 16'hFFFF, 3'd3);
        // ADD
        add_fetch(4'h2, 0, 0);
        add(4'h2, 0, 0, 16'hFFEE, 3'd2);
        add(4'h2, 0, 0, 16'hFDFB, 3'd3);
        add(4'h2, 0, 0, 16'hBF5F, 3'd4);
        add(4'h1, 0, 0, 16'hEFFE, 3'd0);

        #2;
        chk_all("reset", 16'hFFFF, 3'd0, 1'b0);
        do_reset();

        for (int i = 0; i < vecs.size(); i++) begin
            step_en = vecs[i].step_en;
            opcode  = vecs[i].opcode;
            flag_c  = vecs[i].flag_c;
            flag_z  = vecs[i].flag_z;
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].exp_ctrl, vecs[i].exp_t, vecs[i].exp_halted);
            step();
        end

        // step_en low mid-ADD at T3 freezes state; ctrl word stays decoded
        opcode = 4'h2;
        do_reset();
        step(); step(); step();
        chk_all("add_t3", 16'hFDFB, 3'd3, 1'b0);
        step_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_all($sformatf("freeze%0d", i), 16'hFDFB, 3'd3, 1'b0);
        end
        step_en = 1'b1;
        step();
        chk_all("add_t4_after_freeze", 16'hBF5F, 3'd4, 1'b0);

        // Opcode and flag changes act combinationally within a T-state
        opcode = 4'h1;
        do_reset();
        step(); step();
        chk_all("lda_t2", 16'hFFEE, 3'd2, 1'b0);
        opcode = 4'h5;
        #1;
        chk_all("live_ldi_t2", 16'hFFCF, 3'd2, 1'b0);
        opcode = 4'h7;
        flag_c = 1'b0;
        #1;
        chk("live_jc0", 32'(ctrl_n), 32'h0000FFFF);
        flag_c = 1'b1;
        #1;
        chk("live_jc1", 32'(ctrl_n), 32'h0000DFEF);

        // HLT latches and blanks every strobe until reset
        opcode = 4'hF;
        do_reset();
        step(); step();
        chk_all("hlt_t2", 16'h7FFF, 3'd2, 1'b0);
        step();
        chk_all("halted", 16'hFFFF, 3'd2, 1'b1);
        for (int i = 0; i < 12; i++) begin
            opcode  = 4'(i);
            step_en = i[0];
            step();
            chk_all($sformatf("halt_hold%0d", i), 16'hFFFF, 3'd2, 1'b1);
        end
        step_en = 1'b1;
        opcode  = 4'h1;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("halt_reset", 16'hFFFF, 3'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_all("post_halt_t0", 16'hEFFE, 3'd0, 1'b0);
        step();
        chk_all("post_halt_t1", 16'hF7F3, 3'd1, 1'b0);

        // Async reset between edges during STA T3
        opcode = 4'h4;
        do_reset();
        step(); step(); step();
        chk_all("sta_t3", 16'hFFBD, 3'd3, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_reset", 16'hFFFF, 3'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_all("after_async_reset", 16'hEFFE, 3'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
